// File: rtl/iter_add_pkg.sv
// Shared types and constants for the iterative adder: FSM states, saturation limits and
// slice-index sizing.
package iter_add_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   // Widest result the saturation helpers can describe.
   localparam int unsigned MaxWidth = 128;

   function automatic logic [MaxWidth-1:0] sat_max(input int unsigned width);
      logic [MaxWidth-1:0] r;
      r = '0;
      for (int unsigned i = 0; i + 1 < width; i++) r[i] = 1'b1;
      return r;
   endfunction

   function automatic logic [MaxWidth-1:0] sat_min(input int unsigned width);
      logic [MaxWidth-1:0] r;
      r = '0;
      r[width-1] = 1'b1;
      return r;
   endfunction

   function automatic int unsigned idx_width(input int unsigned nslices);
      return (nslices > 1) ? $clog2(nslices) : 1;
   endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder with carry in/out; time-multiplexed across slices by the top.
module chunk_adder #(
   parameter int unsigned CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/iter_adder.sv
// Multi-cycle add/subtract with optional signed saturation, one CHUNK-bit slice per cycle,
// valid/ready handshakes on both sides.
module iter_adder
   import iter_add_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned N    = WIDTH / CHUNK;
   localparam int unsigned IdxW = idx_width(N);
   localparam logic [IdxW-1:0]  LastIdx = IdxW'(N - 1);
   localparam logic [WIDTH-1:0] SatMax  = WIDTH'(sat_max(WIDTH));
   localparam logic [WIDTH-1:0] SatMin  = WIDTH'(sat_min(WIDTH));

   if (CHUNK == 0 || WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("iter_adder: WIDTH must be a non-zero multiple of CHUNK");
   end
   if (WIDTH > MaxWidth) begin : g_bad_width
      $error("iter_adder: WIDTH exceeds MaxWidth");
   end

   state_e           state_q;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic [IdxW-1:0]  idx_q;
   logic             c_q, sat_q, carry_q, ovf_q;

   logic [CHUNK-1:0] slice_s;
   logic             slice_c;
   logic [WIDTH-1:0] res_next;
   logic             ovf_next;

   chunk_adder #(
      .CHUNK (CHUNK)
   ) u_chunk_adder (
      .a    (a_q[idx_q*CHUNK +: CHUNK]),
      .b    (b_q[idx_q*CHUNK +: CHUNK]),
      .cin  (c_q),
      .s    (slice_s),
      .cout (slice_c)
   );

   // Operands are held unshifted, so their sign bits stay visible for the overflow test.
   always_comb begin
      res_next = sum_q;
      res_next[idx_q*CHUNK +: CHUNK] = slice_s;
      ovf_next = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_next[WIDTH-1] != a_q[WIDTH-1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         c_q     <= 1'b0;
         sat_q   <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= sub ? ~b : b;
                  sat_q   <= sat;
                  c_q     <= sub;
                  idx_q   <= '0;
                  state_q <= StRun;
               end
            end
            StRun: begin
               sum_q <= res_next;
               c_q   <= slice_c;
               idx_q <= idx_q + 1'b1;
               if (idx_q == LastIdx) begin
                  idx_q   <= '0;
                  carry_q <= slice_c;
                  ovf_q   <= ovf_next;
                  state_q <= StDone;
                  if (sat_q && ovf_next) sum_q <= a_q[WIDTH-1] ? SatMin : SatMax;
               end
            end
            StDone: begin
               if (out_ready) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign sum       = sum_q;
   assign carry_out = carry_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_iter_adder.sv
// Directed bench for iter_adder: three instances (CHUNK 8, 32, 4) with hand-computed vectors,
// backpressure/isolation and asynchronous reset scenarios.
module tb_iter_adder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] a_in = '0, b_in = '0;
   logic        sub_in = 1'b0, sat_in = 1'b0, out_ready = 1'b0;
   logic        iv8 = 1'b0, iv32 = 1'b0, iv4 = 1'b0;

   logic        ir8, ir32, ir4, ov8, ov32, ov4, co8, co32, co4, of8, of32, of4;
   logic [31:0] sum8, sum32, sum4;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int sel      = 0;

   always #5 clk = ~clk;

   iter_adder #(.WIDTH(32), .CHUNK(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a_in), .b(b_in),
      .sub(sub_in), .sat(sat_in), .out_valid(ov8), .out_ready(out_ready), .sum(sum8),
      .carry_out(co8), .overflow(of8)
   );
   iter_adder #(.WIDTH(32), .CHUNK(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a_in), .b(b_in),
      .sub(sub_in), .sat(sat_in), .out_valid(ov32), .out_ready(out_ready), .sum(sum32),
      .carry_out(co32), .overflow(of32)
   );
   iter_adder #(.WIDTH(32), .CHUNK(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a_in), .b(b_in),
      .sub(sub_in), .sat(sat_in), .out_valid(ov4), .out_ready(out_ready), .sum(sum4),
      .carry_out(co4), .overflow(of4)
   );

   logic        ir_m, ov_m, co_m, of_m;
   logic [31:0] sum_m;
   assign ir_m  = (sel == 0) ? ir8  : (sel == 1) ? ir32  : ir4;
   assign ov_m  = (sel == 0) ? ov8  : (sel == 1) ? ov32  : ov4;
   assign co_m  = (sel == 0) ? co8  : (sel == 1) ? co32  : co4;
   assign of_m  = (sel == 0) ? of8  : (sel == 1) ? of32  : of4;
   assign sum_m = (sel == 0) ? sum8 : (sel == 1) ? sum32 : sum4;

   // Issues one operation to the selected instance and counts edges until out_valid.
   task automatic run_op(input int which, input logic [31:0] ta, input logic [31:0] tb,
                         input logic tsub, input logic tsat, input bit ack, output int lat);
      sel = which;
      @(negedge clk);
      a_in = ta; b_in = tb; sub_in = tsub; sat_in = tsat;
      iv8 = (which == 0); iv32 = (which == 1); iv4 = (which == 2);
      @(posedge clk); #1;
      iv8 = 1'b0; iv32 = 1'b0; iv4 = 1'b0;
      lat = 0;
      while (!ov_m && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      if (ack) begin
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      #2;
      chk_cnt++;
      if ({ir8, ov8, sum8, co8, of8} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0})
         $display("FAIL reset8: got ir=%b ov=%b sum=%h co=%b of=%b want 1 0 0 0 0",
                  ir8, ov8, sum8, co8, of8);
      else pass_cnt++;
      chk_cnt++;
      if ({ir4, ov4, sum4, ir32, ov32, sum32} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0})
         $display("FAIL reset4_32: got ir4=%b ov4=%b sum4=%h ir32=%b ov32=%b sum32=%h",
                  ir4, ov4, sum4, ir32, ov32, sum32);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_vectors(input int which, input int nexp);
      logic [31:0] va [6] = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                              32'h00000005, 32'h80000000};
      logic [31:0] vb [6] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h7, 32'h1};
      logic        vsub [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic        vsat [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] esum [6] = '{32'h00000100, 32'h00000000, 32'h80000000, 32'h7FFFFFFF,
                                32'hFFFFFFFE, 32'h80000000};
      logic        eco [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic        eof [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      int lat;
      for (int i = 0; i < 6; i++) begin
         run_op(which, va[i], vb[i], vsub[i], vsat[i], 1'b1, lat);
         chk_cnt++;
         if (sum_m !== esum[i])
            $display("FAIL vec_sum[%0d] inst%0d: got %h want %h", i, which, sum_m, esum[i]);
         else pass_cnt++;
         chk_cnt++;
         if ({co_m, of_m} !== {eco[i], eof[i]})
            $display("FAIL vec_flags[%0d] inst%0d: got co=%b of=%b want co=%b of=%b",
                     i, which, co_m, of_m, eco[i], eof[i]);
         else pass_cnt++;
         chk_cnt++;
         if (lat !== nexp)
            $display("FAIL vec_latency[%0d] inst%0d: got %0d want %0d", i, which, lat, nexp);
         else pass_cnt++;
         chk_cnt++;
         if ({ov_m, ir_m} !== 2'b01)
            $display("FAIL vec_handshake[%0d] inst%0d: got ov=%b ir=%b want ov=0 ir=1",
                     i, which, ov_m, ir_m);
         else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      int lat;
      run_op(0, 32'd10, 32'd20, 1'b0, 1'b0, 1'b0, lat);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         a_in = $urandom; b_in = $urandom; sub_in = i[1]; sat_in = i[2]; iv8 = i[0];
         @(posedge clk); #1;
         chk_cnt++;
         if ({ov8, ir8, sum8, co8, of8} !== {1'b1, 1'b0, 32'd30, 1'b0, 1'b0})
            $display("FAIL hold[%0d]: got ov=%b ir=%b sum=%h co=%b of=%b want 1 0 1e 0 0",
                     i, ov8, ir8, sum8, co8, of8);
         else pass_cnt++;
      end
      @(negedge clk);
      iv8 = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk_cnt++;
      if ({ov8, ir8, sum8} !== {1'b0, 1'b1, 32'd30})
         $display("FAIL release: got ov=%b ir=%b sum=%h want 0 1 1e", ov8, ir8, sum8);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_run();
      int  lat;
      bit  seen = 1'b0;
      sel = 0;
      @(negedge clk);
      a_in = 32'h11111111; b_in = 32'h22222222; sub_in = 1'b0; sat_in = 1'b0; iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if ({ov8, ir8, sum8, co8, of8} !== {1'b0, 1'b1, 32'h0, 1'b0, 1'b0})
         $display("FAIL mid_reset: got ov=%b ir=%b sum=%h co=%b of=%b want 0 1 0 0 0",
                  ov8, ir8, sum8, co8, of8);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (ov8) seen = 1'b1;
      end
      chk_cnt++;
      if (seen !== 1'b0) $display("FAIL no_pulse: got out_valid pulse=%b want 0", seen);
      else pass_cnt++;
      run_op(0, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1, lat);
      chk_cnt++;
      if ({sum8, co8, of8} !== {32'd7, 1'b0, 1'b0} || lat !== 4)
         $display("FAIL after_reset: got sum=%h co=%b of=%b lat=%0d want 7 0 0 4",
                  sum8, co8, of8, lat);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_vectors(0, 4);
      test_vectors(1, 1);
      test_vectors(2, 8);
      test_backpressure();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
